// File: rtl/evg_event_scheduler.sv
// Event generator slot scheduler: one 16-bit {dbus, event code} word per cycle,
// arbitrating comma, seconds marker, seconds bits and user events.
module evg_event_scheduler #(
   parameter int unsigned SECONDS_WIDTH  = 32,
   parameter int unsigned COMMA_INTERVAL = 64
) (
   input  logic                     evgTxClk,
   input  logic                     evgTxReset,
   input  logic                     ppsIn,
   input  logic [SECONDS_WIDTH-1:0] secondsIn,
   input  logic                     usrValid,
   input  logic [7:0]               usrCode,
   output logic                     usrReady,
   input  logic [7:0]               dbusIn,
   output logic [15:0]              txWord,
   output logic [1:0]               txCharIsK,
   output logic                     secondsBusy,
   output logic                     shiftOverrun,
   output logic                     usrCodeError
);

   localparam int unsigned CntW = (COMMA_INTERVAL > 1) ? $clog2(COMMA_INTERVAL) : 1;
   localparam int unsigned IdxW = (SECONDS_WIDTH > 1) ? $clog2(SECONDS_WIDTH) : 1;
   localparam logic [CntW-1:0] CommaLast = CntW'(COMMA_INTERVAL - 1);
   localparam logic [IdxW-1:0] IdxTop    = IdxW'(SECONDS_WIDTH - 1);

   localparam logic [7:0] CodeIdle   = 8'h00;
   localparam logic [7:0] CodeBit0   = 8'h70;
   localparam logic [7:0] CodeBit1   = 8'h71;
   localparam logic [7:0] CodeMarker = 8'h7D;
   localparam logic [7:0] CodeComma  = 8'hBC;

   typedef enum logic [1:0] {StIdle, StMarker, StShift} state_e;

   state_e                   state_q, state_d;
   logic [CntW-1:0]          comma_cnt_q;
   logic [SECONDS_WIDTH-1:0] shift_q, shift_d;
   logic [IdxW-1:0]          idx_q, idx_d;
   logic [7:0]               code_d;
   logic [1:0]               k_d;

   logic comma_due;
   logic marker_due;
   logic grant_marker;
   logic grant_bit;
   logic usr_reserved;

   assign comma_due    = (comma_cnt_q == CommaLast);
   assign marker_due   = ppsIn | (state_q == StMarker);
   assign grant_marker = marker_due & ~comma_due;
   // A pps in SHIFT preempts the pending bit: the marker owns this slot.
   assign grant_bit    = (state_q == StShift) & ~ppsIn & ~comma_due;
   assign usrReady     = usrValid & ~evgTxReset & ~comma_due & (state_q == StIdle) & ~ppsIn;
   assign usr_reserved = (usrCode == CodeIdle) | (usrCode == CodeBit0) | (usrCode == CodeBit1) |
                         (usrCode == CodeMarker) | (usrCode == CodeComma);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      code_d  = CodeIdle;
      k_d     = 2'b00;

      if (comma_due) begin
         code_d = CodeComma;
         k_d    = 2'b01;
      end else if (grant_marker) begin
         code_d = CodeMarker;
      end else if (grant_bit) begin
         code_d = shift_q[idx_q] ? CodeBit1 : CodeBit0;
      end else if (usrReady && !usr_reserved) begin
         code_d = usrCode;
      end

      if (ppsIn) begin
         shift_d = secondsIn;
         idx_d   = IdxTop;
         state_d = grant_marker ? StShift : StMarker;
      end else begin
         case (state_q)
            StMarker: begin
               if (grant_marker) begin
                  state_d = StShift;
                  idx_d   = IdxTop;
               end
            end
            StShift: begin
               if (grant_bit) begin
                  if (idx_q == '0) begin
                     state_d = StIdle;
                  end else begin
                     idx_d = idx_q - IdxW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge evgTxClk) begin
      if (evgTxReset) begin
         state_q      <= StIdle;
         comma_cnt_q  <= '0;
         shift_q      <= '0;
         idx_q        <= '0;
         txWord       <= 16'h0000;
         txCharIsK    <= 2'b00;
         secondsBusy  <= 1'b0;
         shiftOverrun <= 1'b0;
         usrCodeError <= 1'b0;
      end else begin
         state_q      <= state_d;
         comma_cnt_q  <= comma_due ? '0 : comma_cnt_q + CntW'(1);
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         txWord       <= {dbusIn, code_d};
         txCharIsK    <= k_d;
         // Describes the slot being launched, so it lines up with txWord.
         secondsBusy  <= marker_due | (state_q == StShift);
         shiftOverrun <= ppsIn & (state_q == StShift);
         usrCodeError <= usrReady & usr_reserved;
      end
   end

endmodule

// File: tb/tb_evg_event_scheduler.sv
// Directed bench for evg_event_scheduler: vector table for user slots plus
// hand-built seconds-marker, comma-collision, overrun and reset sequences.
module tb_evg_event_scheduler;

   localparam logic [7:0] CIdle   = 8'h00;
   localparam logic [7:0] CMarker = 8'h7D;
   localparam logic [7:0] CComma  = 8'hBC;
   localparam logic [7:0] CUser   = 8'h05;
   localparam logic [7:0] SeqDbus = 8'h3C;

   logic        clk;
   logic        rst;
   logic        pps;
   logic [31:0] secs;
   logic        uvalid;
   logic [7:0]  ucode;
   logic        ready;
   logic [7:0]  dbus;
   logic [15:0] word;
   logic [1:0]  isk;
   logic        busy;
   logic        ovr;
   logic        uerr;

   int checks;
   int errors;
   int cyc;

   typedef struct {
      logic        valid;
      logic [7:0]  code;
      logic [7:0]  dbus;
      logic [15:0] word;
      logic        err;
      logic        ready;
   } vec_t;

   vec_t vecs[10];

   evg_event_scheduler dut (
      .evgTxClk     (clk),
      .evgTxReset   (rst),
      .ppsIn        (pps),
      .secondsIn    (secs),
      .usrValid     (uvalid),
      .usrCode      (ucode),
      .usrReady     (ready),
      .dbusIn       (dbus),
      .txWord       (word),
      .txCharIsK    (isk),
      .secondsBusy  (busy),
      .shiftOverrun (ovr),
      .usrCodeError (uerr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic do_cycle(input logic p, input logic [31:0] s, input logic v,
                           input logic [7:0] c, input logic [7:0] d,
                           input logic [15:0] ew, input logic [1:0] ek, input logic eb,
                           input logic eo, input logic ee, input logic er, input string tag);
      pps    = p;
      secs   = s;
      uvalid = v;
      ucode  = c;
      dbus   = d;
      #1;
      chk({tag, " usrReady"}, 32'(ready), 32'(er));
      @(posedge clk);
      #1;
      chk({tag, " txWord"}, 32'(word), 32'(ew));
      chk({tag, " txCharIsK"}, 32'(isk), 32'(ek));
      chk({tag, " secondsBusy"}, 32'(busy), 32'(eb));
      chk({tag, " shiftOverrun"}, 32'(ovr), 32'(eo));
      chk({tag, " usrCodeError"}, 32'(uerr), 32'(ee));
      cyc++;
   endtask

   // Reset with pps and a user request active, which must both be ignored.
   task automatic reset_dut();
      rst    = 1'b1;
      pps    = 1'b1;
      secs   = 32'hFFFF_FFFF;
      uvalid = 1'b1;
      ucode  = CUser;
      dbus   = 8'hAA;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("reset usrReady", 32'(ready), 32'd0);
         chk("reset txWord", 32'(word), 32'h0000);
         chk("reset txCharIsK", 32'(isk), 32'd0);
         chk("reset secondsBusy", 32'(busy), 32'd0);
         chk("reset shiftOverrun", 32'(ovr), 32'd0);
         chk("reset usrCodeError", 32'(uerr), 32'd0);
      end
      rst    = 1'b0;
      pps    = 1'b0;
      uvalid = 1'b0;
      dbus   = 8'h00;
      cyc    = 0;
   endtask

   task automatic idle_until(input int target, input logic uv);
      logic       comma;
      logic [7:0] d;
      while (cyc < target) begin
         comma = (cyc % 64 == 63);
         d     = 8'(cyc) ^ 8'h5A;
         do_cycle(1'b0, 32'h0, uv, CUser, d,
                  {d, comma ? CComma : (uv ? CUser : CIdle)}, comma ? 2'b01 : 2'b00,
                  1'b0, 1'b0, 1'b0, uv && !comma, "idle");
      end
   endtask

   // Pulse pps with sec, then expect marker and 32 bits MSB first, with commas
   // slotted in on their own schedule; stops early after max_n cycles.
   task automatic seq(input logic [31:0] sec, input int max_n, input logic exp_ov,
                      input logic uv);
      logic [7:0] q[$];
      logic       tail;
      logic       comma;
      logic       busy_e;
      logic [7:0] code_e;
      int         n;
      tail = 1'b0;
      n    = 0;
      q.push_back(CMarker);
      for (int i = 31; i >= 0; i--) q.push_back(sec[i] ? 8'h71 : 8'h70);
      while (n < max_n && !tail) begin
         comma  = (cyc % 64 == 63);
         busy_e = (q.size() != 0);
         if (!busy_e) tail = 1'b1;
         if (comma) code_e = CComma;
         else if (busy_e) code_e = q.pop_front();
         else code_e = uv ? CUser : CIdle;
         do_cycle(n == 0, sec, uv, CUser, SeqDbus, {SeqDbus, code_e},
                  comma ? 2'b01 : 2'b00, busy_e, exp_ov && (n == 0), 1'b0,
                  uv && !busy_e && !comma, "seq");
         n++;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst    = 1'b1;
      pps    = 1'b0;
      secs   = 32'h0;
      uvalid = 1'b0;
      ucode  = 8'h00;
      dbus   = 8'h00;

      vecs[0] = '{1'b1, 8'h05, 8'h11, 16'h1105, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 8'h7D, 8'h22, 16'h2200, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 8'h05, 8'h33, 16'h3300, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h00, 8'h44, 16'h4400, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 8'h70, 8'h55, 16'h5500, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 8'h71, 8'h66, 16'h6600, 1'b1, 1'b1};
      vecs[6] = '{1'b1, 8'hBC, 8'h77, 16'h7700, 1'b1, 1'b1};
      vecs[7] = '{1'b1, 8'hFF, 8'h88, 16'h88FF, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 8'h7C, 8'h99, 16'h997C, 1'b0, 1'b1};
      vecs[9] = '{1'b0, 8'h7D, 8'h00, 16'h0000, 1'b0, 1'b0};

      reset_dut();

      for (int i = 0; i < 10; i++) begin
         do_cycle(1'b0, 32'h0, vecs[i].valid, vecs[i].code, vecs[i].dbus, vecs[i].word,
                  2'b00, 1'b0, 1'b0, vecs[i].err, vecs[i].ready, "vec");
      end

      // Comma cadence from release: output in cycles 64 and 128.
      idle_until(130, 1'b0);
      // Plain marker + bits with a user request pending throughout.
      seq(32'h8000_0001, 1000, 1'b0, 1'b1);
      idle_until(170, 1'b1);
      idle_until(191, 1'b0);
      // Comma collides with the marker grant.
      seq(32'hA5C3_0F96, 1000, 1'b0, 1'b0);
      idle_until(240, 1'b0);
      // Comma lands mid-shift and must delay, not drop, a bit.
      seq(32'h1234_5678, 1000, 1'b0, 1'b0);
      idle_until(319, 1'b0);
      // Second pps while still in MARKER: one marker, new value, no overrun.
      seq(32'hDEAD_BEEF, 1, 1'b0, 1'b0);
      seq(32'h0F0F_0F0F, 1000, 1'b0, 1'b0);
      idle_until(360, 1'b0);
      // Second pps 10 cycles in: overrun pulse and full restart.
      seq(32'hFFFF_0000, 10, 1'b0, 1'b0);
      seq(32'h0000_FFFF, 1000, 1'b1, 1'b0);
      // Reset mid-shift discards the shift and restarts the comma count.
      seq(32'h5555_5555, 5, 1'b0, 1'b0);
      reset_dut();
      idle_until(70, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/evg_event_scheduler.md
EVG_EVENT_SCHEDULER -- requirements
Module: evg_event_scheduler

Interface
REQ-001 Parameter SECONDS_WIDTH, default 32: bits of seconds value shifted per second.
REQ-002 Parameter COMMA_INTERVAL, default 64: cycles between forced K28.5 comma slots, minimum 4.
REQ-003 evgTxClk  in  1: single clock; all logic on its rising edge.
REQ-004 evgTxReset  in  1: reset, synchronous and active-high.
REQ-005 ppsIn  in  1: one-cycle pulse requesting a seconds marker.
REQ-006 secondsIn  in  SECONDS_WIDTH: value announced at the next marker, sampled when ppsIn=1.
REQ-007 usrValid  in  1: user event request.
REQ-008 usrCode  in  8: user event code.
REQ-009 usrReady  out  1: combinational grant; transfer occurs when usrValid=1 and usrReady=1.
REQ-010 dbusIn  in  8: distributed data bus byte.
REQ-011 txWord  out  16: {distributed data byte, event code}, registered.
REQ-012 txCharIsK  out  2: K flags for txWord, registered.
REQ-013 secondsBusy  out  1: marker pending or shift in progress.
REQ-014 shiftOverrun  out  1: one-cycle pulse, ppsIn arrived before shift completed.
REQ-015 usrCodeError  out  1: one-cycle pulse, reserved user code accepted and dropped.

Function
REQ-016 One slot per cycle; slot granted in cycle N SHALL appear on txWord/txCharIsK in cycle N+1.
REQ-017 Slot priority SHALL be: comma > marker > shift bit > user > idle.
REQ-018 Comma counter SHALL count 0..COMMA_INTERVAL-1 and wrap; comma due in the cycle the count equals COMMA_INTERVAL-1.
REQ-019 Comma slot SHALL drive txWord[7:0]=0xBC, txCharIsK=2'b01.
REQ-020 Non-comma slots SHALL drive txCharIsK=2'b00; txWord[15:8]=dbusIn of the grant cycle in every slot.
REQ-021 Idle slot SHALL drive txWord[7:0]=0x00.
REQ-022 FSM states: IDLE, MARKER, SHIFT.
REQ-023 ppsIn=1 in any state SHALL capture secondsIn into the shift register and make the marker due in that same cycle; the FSM SHALL be in MARKER until the marker is granted.
REQ-024 Marker slot SHALL drive txWord[7:0]=0x7D; after the grant the FSM SHALL enter SHIFT with bit index SECONDS_WIDTH-1.
REQ-025 SHIFT SHALL send one bit per granted slot, MSB first, code 0x70 for 0 and 0x71 for 1; a comma preempting a bit SHALL delay that bit, not skip it.
REQ-026 After bit 0 is granted the FSM SHALL return to IDLE.
REQ-027 ppsIn=1 while in SHIFT SHALL abandon remaining bits, pulse shiftOverrun next cycle, and restart per REQ-023.
REQ-028 ppsIn=1 while in MARKER SHALL re-capture secondsIn, send a single marker, with no overrun pulse.
REQ-029 usrReady SHALL be 1 only when usrValid=1, evgTxReset=0, no comma due, FSM in IDLE, no ppsIn.
REQ-030 User codes 0x00, 0x70, 0x71, 0x7D, 0xBC SHALL be accepted, not transmitted (idle slot), and pulse usrCodeError next cycle.
REQ-031 secondsBusy SHALL be 1 in MARKER and SHIFT, registered alongside txWord.

Reset
REQ-032 While evgTxReset=1: txWord=0x0000, txCharIsK=2'b00, secondsBusy=0, shiftOverrun=0, usrCodeError=0, usrReady=0, FSM=IDLE, comma counter=0, ppsIn ignored.
REQ-033 Reset mid-shift SHALL discard the shift; first comma SHALL be granted COMMA_INTERVAL-1 cycles after reset release.

Verification
REQ-034 Reset release, idle inputs, COMMA_INTERVAL=64 -> txWord[7:0]=0xBC, K=01 first in cycle 64 after release, then every 64 cycles; 0x00 otherwise.
REQ-035 ppsIn=1 with secondsIn=0x8000_0001 in cycle N, no comma nearby -> 0x7D in N+1; 0x71, thirty 0x70, 0x71 in N+2..N+33; secondsBusy drops in N+34.
REQ-036 Comma due in the marker grant cycle -> 0xBC in N+1, 0x7D in N+2, all 32 bits following intact.
REQ-037 Continuous usrValid=1, usrCode=0x05 during seconds sequence -> usrReady=0 until FSM idle, then 0x05 every non-comma slot.
REQ-038 Second ppsIn 10 cycles after first -> shiftOverrun pulse, new 0x7D, full 32 bits of new value.
REQ-039 usrCode=0x7D with usrValid=1 while idle -> usrReady=1, usrCodeError pulse next cycle, txWord[7:0]=0x00.
